fetch_pc_unit: RTL

Program-counter and instruction-fetch stage that sits directly upstream of the jump-address shifter and decode. Holds the architectural PC and issues single-outstanding word fetches to instruction memory. Presents the fetched instruction together with its PC, which the jump-address shifter combines into a jump target. Accepts jump and branch redirects that flush any in-flight fetch.

---
 rtl/fetch_pc_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch stage.
// Presents each fetched word with its PC; jump/branch redirects flush any in-flight fetch.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetN,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic [31:0] imemRdata,
  input  logic        imemRvalid,
  output logic [31:0] instructionOut,
  output logic [31:0] PCOut,
  output logic [31:0] pcPlus4Out,
  output logic        instrValid,
  input  logic        stall,
  input  logic        jumpTaken,
  input  logic [31:0] jumpAddress,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DISCARD} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_reqPC;
  logic [31:0] r_instr;
  logic [31:0] r_pcOut;
  logic [31:0] r_pcPlus4;
  logic        r_valid;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_consume;
  logic        w_req;
  logic        w_accept;

  // Jump wins over branch; targets are forced word-aligned.
  assign w_redirect = jumpTaken | branchTaken;
  assign w_target   = (jumpTaken ? jumpAddress : branchTarget) & ~32'h3;
  assign w_consume  = r_valid & ~stall;

  // Only request when the output slot is empty or being drained this cycle,
  // so a returning word can never land on an unconsumed instruction.
  assign w_req    = (r_state == FETCH) & ~(r_valid & stall);
  assign w_accept = w_req & imemGnt;

  assign imemReq        = w_req;
  assign imemAddr       = r_pc;
  assign instructionOut = r_instr;
  assign PCOut          = r_pcOut;
  assign pcPlus4Out     = r_pcPlus4;
  assign instrValid     = r_valid;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_reqPC   <= 32'h0;
      r_instr   <= 32'h0;
      r_pcOut   <= 32'h0;
      r_pcPlus4 <= 32'h4;
      r_valid   <= 1'b0;
    end else begin
      if (w_consume) r_valid <= 1'b0;

      case (r_state)
        IDLE: r_state <= FETCH;
        FETCH: begin
          if (w_accept) begin
            r_reqPC <= r_pc;
            r_pc    <= r_pc + 32'd4;
            // A fetch granted alongside a redirect is already stale.
            r_state <= w_redirect ? DISCARD : WAIT;
          end
        end
        WAIT: begin
          if (imemRvalid) begin
            r_state <= FETCH;
            if (!w_redirect) begin
              r_instr   <= imemRdata;
              r_pcOut   <= r_reqPC;
              r_pcPlus4 <= r_reqPC + 32'd4;
              r_valid   <= 1'b1;
            end
          end else if (w_redirect) begin
            r_state <= DISCARD;
          end
        end
        DISCARD: begin
          if (imemRvalid) r_state <= FETCH;
        end
        default: r_state <= IDLE;
      endcase

      // Redirect overrides both the sequential pc advance and any load.
      if (w_redirect) begin
        r_pc    <= w_target;
        r_valid <= 1'b0;
      end
    end
  end

endmodule
